// File: rtl/mac_pkg.sv
// Shared types for the multi-channel memory access arbiter.
// FSM state encoding and index-width helper.
package mac_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      DONE     = 2'd2,
      ERR      = 2'd3
   } mac_state_t;

   function automatic int mac_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Requester/memory-side bundle of the memory access arbiter.
// master = arbiter view, slave = requesters plus memory.
interface mem_access_arbiter_if
   import mac_pkg::*;
#(
   parameter int NCH = 2
);

   logic [NCH-1:0] MR;
   logic [NCH-1:0] MW;
   logic           ACK_N;
   logic           AS_N;
   logic           WR;
   logic [NCH-1:0] GRANT;
   logic [NCH-1:0] BUSY;
   logic           STOP_N;
   mac_state_t     STATE;
   logic           TIMEOUT;

   modport master (
      input  MR, MW, ACK_N,
      output AS_N, WR, GRANT, BUSY, STOP_N, STATE, TIMEOUT
   );

   modport slave (
      output MR, MW, ACK_N,
      input  AS_N, WR, GRANT, BUSY, STOP_N, STATE, TIMEOUT
   );

endinterface

// File: rtl/mac_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr,
// otherwise wraps to the lowest requester.
module mac_rr_arbiter
   import mac_pkg::*;
#(
   parameter  int NCH = 2,
   localparam int IW  = mac_idx_w(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [IW-1:0]  ptr,
   output logic [NCH-1:0] win,
   output logic [IW-1:0]  idx,
   output logic           any
);

   always_comb begin
      win = '0;
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (!any && req[i] && (IW'(i) >= ptr)) begin
            any    = 1'b1;
            win[i] = 1'b1;
            idx    = IW'(i);
         end
      end
      for (int i = 0; i < NCH; i++) begin
         if (!any && req[i]) begin
            any    = 1'b1;
            win[i] = 1'b1;
            idx    = IW'(i);
         end
      end
   end

endmodule

// File: rtl/mem_access_arbiter.sv
// Multi-channel memory access arbiter with ACK_N handshake.
// Define MAC_TIMEOUT_EN to enable the no-ACK watchdog abort.
module mem_access_arbiter
   import mac_pkg::*;
#(
   parameter  int NCH      = 2,
   parameter  int WCNT_W   = 4,
   parameter  int TO_LIMIT = 15,
   localparam int IW       = mac_idx_w(NCH)
) (
   input logic                  CLK,
   input logic                  RESET,
   mem_access_arbiter_if.master bus
);

   localparam logic [WCNT_W-1:0] CNT_MAX = '1;
   localparam logic [WCNT_W-1:0] TO_CNT  = WCNT_W'(TO_LIMIT);
   localparam logic [IW-1:0]     LAST    = IW'(NCH - 1);

   mac_state_t        state_q, state_d;
   logic [NCH-1:0]    grant_q, grant_d;
   logic              as_n_q, as_n_d;
   logic              wr_q, wr_d;
   logic [WCNT_W-1:0] cnt_q, cnt_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     idx_q, idx_d;

   logic [NCH-1:0]    req;
   logic [NCH-1:0]    win;
   logic [IW-1:0]     win_idx;
   logic              any_req;
   logic              ack;
   logic              waiting;
   logic              to_hit;
   logic [IW-1:0]     ptr_nxt;

   assign req     = bus.MR | bus.MW;
   assign ack     = ~bus.ACK_N;
   assign waiting = (state_q == WAIT_ACK);
   assign to_hit  = waiting & ~ack & (cnt_q == TO_CNT);
   assign ptr_nxt = (idx_q == LAST) ? '0 : idx_q + 1'b1;

   mac_rr_arbiter #(.NCH(NCH)) u_rr (
      .req (req),
      .ptr (ptr_q),
      .win (win),
      .idx (win_idx),
      .any (any_req)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      as_n_d  = as_n_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d = win;
               idx_d   = win_idx;
               wr_d    = |(bus.MW & win);
               as_n_d  = 1'b0;
               cnt_d   = '0;
               state_d = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (ack) begin
               state_d = DONE;
            end else begin
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
`ifdef MAC_TIMEOUT_EN
               if (to_hit) state_d = ERR;
`endif
            end
         end
         DONE: begin
            grant_d = '0;
            as_n_d  = 1'b1;
            cnt_d   = '0;
            ptr_d   = ptr_nxt;
            state_d = IDLE;
         end
`ifdef MAC_TIMEOUT_EN
         ERR: begin
            grant_d = '0;
            as_n_d  = 1'b1;
            cnt_d   = '0;
            ptr_d   = ptr_nxt;
            state_d = IDLE;
         end
`endif
         default: begin
            grant_d = '0;
            as_n_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         grant_q <= '0;
         as_n_q  <= 1'b1;
         wr_q    <= 1'b0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         as_n_q  <= as_n_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.STATE  = state_q;
   assign bus.GRANT  = grant_q;
   assign bus.AS_N   = as_n_q;
   assign bus.WR     = wr_q;
   // A loser, or the owner before its ACK, keeps its requester stalled
   assign bus.BUSY   = req & ~(grant_q & {NCH{waiting & ack}});
   assign bus.STOP_N = ~(waiting & (cnt_q != '0) & ~ack);

`ifdef MAC_TIMEOUT_EN
   assign bus.TIMEOUT = (state_q == ERR);
`else
   logic unused_to;
   assign unused_to   = to_hit;
   assign bus.TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed-vector bench for mem_access_arbiter (NCH=2, TO_LIMIT=3).
// Vector = {RESET, MR, MW, ACK_N, {STATE,GRANT,AS_N,WR,BUSY,STOP_N,TIMEOUT}}.
module tb_mem_access_arbiter;

   logic clk;
   logic rst;
   int   nvec;
   int   nerr;

   mem_access_arbiter_if #(.NCH(2)) bus ();

   mem_access_arbiter #(
      .NCH      (2),
      .WCNT_W   (4),
      .TO_LIMIT (3)
   ) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [9:0] obs;
   assign obs = {bus.STATE, bus.GRANT, bus.AS_N, bus.WR,
                 bus.BUSY, bus.STOP_N, bus.TIMEOUT};

   localparam logic [15:0] T1 [3] = '{
      16'b1_00_00_1_00_00_1_0_00_1_0,
      16'b0_00_00_0_00_00_1_0_00_1_0,
      16'b0_00_00_1_00_00_1_0_00_1_0
   };

   localparam logic [15:0] T2 [4] = '{
      16'b0_01_00_1_00_00_1_0_01_1_0,
      16'b0_01_00_0_01_01_0_0_00_1_0,
      16'b0_00_00_1_10_01_0_0_00_1_0,
      16'b0_00_00_1_00_00_1_0_00_1_0
   };

   localparam logic [15:0] T3 [7] = '{
      16'b0_00_10_1_00_00_1_0_10_1_0,
      16'b0_00_10_1_01_10_0_1_10_1_0,
      16'b0_00_10_1_01_10_0_1_10_0_0,
      16'b0_00_10_1_01_10_0_1_10_0_0,
      16'b0_00_10_0_01_10_0_1_00_1_0,
      16'b0_00_00_1_10_10_0_1_00_1_0,
      16'b0_00_00_1_00_00_1_1_00_1_0
   };

   localparam logic [15:0] T4 [10] = '{
      16'b0_11_00_1_00_00_1_1_11_1_0,
      16'b0_11_00_0_01_01_0_0_10_1_0,
      16'b0_11_00_1_10_01_0_0_11_1_0,
      16'b0_11_00_1_00_00_1_0_11_1_0,
      16'b0_11_00_0_01_10_0_0_01_1_0,
      16'b0_11_00_1_10_10_0_0_11_1_0,
      16'b0_11_00_1_00_00_1_0_11_1_0,
      16'b0_11_00_0_01_01_0_0_10_1_0,
      16'b0_00_00_1_10_01_0_0_00_1_0,
      16'b0_00_00_1_00_00_1_0_00_1_0
   };

   localparam logic [15:0] T5 [4] = '{
      16'b0_01_00_1_00_00_1_0_01_1_0,
      16'b0_01_00_1_01_01_0_0_01_1_0,
      16'b1_01_00_1_01_01_0_0_01_0_0,
      16'b0_00_00_1_00_00_1_0_00_1_0
   };

   localparam logic [15:0] T6 [10] = '{
      16'b0_11_00_1_00_00_1_0_11_1_0,
      16'b0_11_00_1_01_01_0_0_11_1_0,
      16'b0_11_00_1_01_01_0_0_11_0_0,
      16'b0_11_00_1_01_01_0_0_11_0_0,
      16'b0_11_00_1_01_01_0_0_11_0_0,
      16'b0_11_00_1_11_01_0_0_11_1_1,
      16'b0_11_00_1_00_00_1_0_11_1_0,
      16'b0_11_00_0_01_10_0_0_01_1_0,
      16'b0_00_00_1_10_10_0_0_00_1_0,
      16'b0_00_00_1_00_00_1_0_00_1_0
   };

   task automatic apply(input logic [15:0] v);
      @(negedge clk);
      rst       = v[15];
      bus.MR    = v[14:13];
      bus.MW    = v[12:11];
      bus.ACK_N = v[10];
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] v;
      rst       = 1'b1;
      bus.MR    = '0;
      bus.MW    = '0;
      bus.ACK_N = 1'b1;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         v = T1[i];
         apply(v);
         nvec++;
         if (obs !== v[9:0]) begin
            nerr++;
            $display("FAIL reset c%0d got %b exp %b", i, obs, v[9:0]);
         end
      end
   endtask

   task automatic test_single_read();
      logic [15:0] v;
      for (int i = 0; i < 4; i++) begin
         v = T2[i];
         apply(v);
         nvec++;
         if (obs !== v[9:0]) begin
            nerr++;
            $display("FAIL single_read c%0d got %b exp %b", i, obs, v[9:0]);
         end
      end
   endtask

   task automatic test_wait_write();
      logic [15:0] v;
      for (int i = 0; i < 7; i++) begin
         v = T3[i];
         apply(v);
         nvec++;
         if (obs !== v[9:0]) begin
            nerr++;
            $display("FAIL wait_write c%0d got %b exp %b", i, obs, v[9:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] v;
      for (int i = 0; i < 10; i++) begin
         v = T4[i];
         apply(v);
         nvec++;
         if (obs !== v[9:0]) begin
            nerr++;
            $display("FAIL back_to_back c%0d got %b exp %b", i, obs, v[9:0]);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [15:0] v;
      for (int i = 0; i < 4; i++) begin
         v = T5[i];
         apply(v);
         nvec++;
         if (obs !== v[9:0]) begin
            nerr++;
            $display("FAIL mid_reset c%0d got %b exp %b", i, obs, v[9:0]);
         end
      end
   endtask

`ifdef MAC_TIMEOUT_EN
   task automatic test_timeout();
      logic [15:0] v;
      for (int i = 0; i < 10; i++) begin
         v = T6[i];
         apply(v);
         nvec++;
         if (obs !== v[9:0]) begin
            nerr++;
            $display("FAIL timeout c%0d got %b exp %b", i, obs, v[9:0]);
         end
      end
   endtask
`else
   task automatic test_timeout();
      logic [15:0] v;
      logic [9:0]  e;
      v = T6[0];
      apply(v);
      nvec++;
      if (obs !== v[9:0]) begin
         nerr++;
         $display("FAIL no_timeout grant got %b exp %b", obs, v[9:0]);
      end
      for (int i = 1; i <= 40; i++) begin
         apply(16'b0_11_00_1_00_00_0_0_00_0_0);
         e = (i == 1) ? 10'b01_01_0_0_11_1_0 : 10'b01_01_0_0_11_0_0;
         nvec++;
         if (obs !== e) begin
            nerr++;
            $display("FAIL no_timeout c%0d got %b exp %b", i, obs, e);
         end
      end
      apply(16'b0_11_00_0_00_00_0_0_00_0_0);
      nvec++;
      if (obs !== 10'b01_01_0_0_10_1_0) begin
         nerr++;
         $display("FAIL no_timeout ack got %b exp 0101001010", obs);
      end
      apply(16'b0_00_00_1_00_00_0_0_00_0_0);
      nvec++;
      if (obs !== 10'b10_01_0_0_00_1_0) begin
         nerr++;
         $display("FAIL no_timeout done got %b exp 1001000010", obs);
      end
      apply(16'b0_00_00_1_00_00_0_0_00_0_0);
      nvec++;
      if (obs !== 10'b00_00_1_0_00_1_0) begin
         nerr++;
         $display("FAIL no_timeout idle got %b exp 0000100010", obs);
      end
   endtask
`endif

   initial begin
      nvec = 0;
      nerr = 0;
      test_reset();
      test_single_read();
      test_wait_write();
      test_back_to_back();
      test_mid_reset();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
